// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INST_NOP         = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  // Force word alignment by clearing the two byte-offset bits.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & {{(XLEN-2){1'b1}}, 2'b00};
  endfunction

  function automatic logic is_misaligned(input logic [XLEN-1:0] pc);
    return |pc[1:0];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: small circular FIFO of {pc, instruction} pairs.
// DEPTH must be a power of two (2 or 4) so the pointers wrap naturally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [XLEN-1:0]  push_pc,
  input  logic [XLEN-1:0]  push_data,
  output logic [CNT_W-1:0] count,
  output logic [XLEN-1:0]  head_pc,
  output logic [XLEN-1:0]  head_data
);

  logic [XLEN-1:0]  mem_pc   [DEPTH];
  logic [XLEN-1:0]  mem_data [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Head is forced to zero when empty so the decoder never sees stale words.
  assign head_pc   = empty ? '0 : mem_pc[rd_ptr];
  assign head_data = empty ? '0 : mem_data[rd_ptr];

  // Storage, pointers and occupancy; flush wins over push/pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]   <= '0;
        mem_data[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem_pc[wr_ptr]   <= push_pc;
        mem_data[wr_ptr] <= push_data;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory read at a time, results
// queued in a prefetch FIFO toward the decoder, redirects flush everything.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN -- when defined, a redirect
// to a non-word-aligned address raises a sticky fetch_fault and halts fetch
// until an aligned redirect or reset; when undefined the low bits are dropped.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_REQ   | issue/hold a read at fetch_pc whenever the FIFO has room
// ST_DRAIN | hold the abandoned read until acked, then discard its data
// ST_HALT  | misaligned redirect seen, no reads until aligned redirect
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        fetch_fault
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_e     state_q;
  fetch_state_e     state_d;
  logic [XLEN-1:0]  fetch_pc_q;
  logic [XLEN-1:0]  fetch_pc_d;
  logic [XLEN-1:0]  drain_addr_q;
  logic [XLEN-1:0]  drain_addr_d;
  logic             fault_q;
  logic             fault_d;
  logic             req_raw;
  logic             ack_taken;
  logic             push;
  logic             pop;
  logic             misalign;
  logic [CNT_W-1:0] fifo_count;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign    = redirect_valid && is_misaligned(redirect_pc);
  assign fetch_fault = fault_q;
`else
  assign misalign    = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  // The request is masked while reset is low so no read is presented during
  // reset, and the first read appears in the first cycle after release.
  assign imem_req   = req_raw && reset;
  assign inst_valid = (fifo_count != '0);

  // Next-state, request generation and FIFO control; redirect has priority.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    drain_addr_d = drain_addr_q;
    fault_d      = fault_q;
    req_raw      = 1'b0;
    imem_addr    = fetch_pc_q;
    push         = 1'b0;
    pop          = 1'b0;

    case (state_q)
      ST_REQ: begin
        req_raw   = (fifo_count < CNT_W'(FIFO_DEPTH));
        imem_addr = fetch_pc_q;
      end
      ST_DRAIN: begin
        req_raw   = 1'b1;
        imem_addr = drain_addr_q;
      end
      default: begin
        req_raw   = 1'b0;
        imem_addr = fetch_pc_q;
      end
    endcase

    ack_taken = req_raw && imem_ack;

    if (redirect_valid) begin
      fetch_pc_d = align_pc(redirect_pc);
      fault_d    = misalign;
      if (req_raw && !imem_ack) begin
        // Read still in flight: keep its address on the bus until acked.
        state_d      = ST_DRAIN;
        drain_addr_d = imem_addr;
      end else begin
        state_d = misalign ? ST_HALT : ST_REQ;
      end
    end else begin
      pop = inst_valid && inst_ready;
      case (state_q)
        ST_REQ: begin
          if (ack_taken) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end
        ST_DRAIN: begin
          if (imem_ack) begin
            state_d = fault_q ? ST_HALT : ST_REQ;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_REQ;
      fetch_pc_q   <= RESET_PC;
      drain_addr_q <= RESET_PC;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      drain_addr_q <= drain_addr_d;
      fault_q      <= fault_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_valid),
    .push_pc   (fetch_pc_q),
    .push_data (imem_rdata),
    .count     (fifo_count),
    .head_pc   (inst_pc),
    .head_data (inst_data)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 2;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam bit MISALIGN_EN = 1'b1;
`else
  localparam bit MISALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        fetch_fault;

  fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h20) ? INST_NOP : (a ^ 32'hC0DE_0001);
  endfunction

  // Reference model: queue of fetched {pc,data}, next fetch address, and
  // whether an abandoned read is still on the bus.
  logic [63:0] mq[$];
  logic [31:0] m_fpc = 32'h0;
  logic [31:0] m_pend = 32'h0;
  bit          m_stale = 1'b0;
  bit          m_halt = 1'b0;
  bit          m_fault = 1'b0;

  function automatic bit m_req();
    return reset && (m_stale || (!m_halt && mq.size() < DEPTH));
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_fpc   = 32'h0;
      m_pend  = 32'h0;
      m_stale = 1'b0;
      m_halt  = 1'b0;
      m_fault = 1'b0;
    end else begin
      bit req;
      bit acked;
      bit mis;
      req   = m_req();
      acked = req && imem_ack;
      if (redirect_valid) begin
        mq.delete();
        mis = MISALIGN_EN && (redirect_pc[1:0] != 2'b00);
        if (req && !acked) begin
          if (!m_stale) m_pend = m_fpc;
          m_stale = 1'b1;
        end else begin
          m_stale = 1'b0;
        end
        m_fpc   = redirect_pc - (redirect_pc % 4);
        m_fault = mis;
        m_halt  = mis;
      end else begin
        if (mq.size() > 0 && inst_ready) void'(mq.pop_front());
        if (acked) begin
          if (m_stale) m_stale = 1'b0;
          else begin
            mq.push_back({m_fpc, imem_rdata});
            m_fpc = m_fpc + 32'd4;
          end
        end
      end
    end
  end

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      bit er;
      er = m_req();
      chk1("imem_req", imem_req, er);
      if (er) chk("imem_addr", imem_addr, m_stale ? m_pend : m_fpc);
      chk1("inst_valid", inst_valid, mq.size() > 0);
      if (mq.size() > 0) begin
        chk("inst_pc", inst_pc, mq[0][63:32]);
        chk("inst_data", inst_data, mq[0][31:0]);
      end
      chk1("fetch_fault", fetch_fault, m_fault);
    end
  end

  // Log of addresses the decoder actually accepted.
  logic [31:0] acc[$];
  always @(negedge clk) begin
    if (reset && inst_valid && inst_ready && !redirect_valid) acc.push_back(inst_pc);
  end

  function automatic logic [31:0] acc_at(input int i);
    return (i < acc.size()) ? acc[i] : 32'hDEAD_BEEF;
  endfunction

  // Memory responder settings.
  bit tie_ack = 1'b0;
  int ack_delay = 0;
  int wait_cnt = 0;

  task automatic mem_drive(input bit req_was, input bit ack_was);
    if (!req_was || ack_was) wait_cnt = 0;
    else wait_cnt++;
    imem_rdata = mem_word(imem_addr);
    imem_ack   = tie_ack ? 1'b1 : (imem_req && (wait_cnt >= ack_delay));
  endtask

  task automatic step(input bit rv, input logic [31:0] rpc, input bit rdy);
    bit req_was;
    bit ack_was;
    req_was = imem_req;
    ack_was = imem_ack;
    @(posedge clk);
    #1;
    redirect_valid = rv;
    redirect_pc    = rpc;
    inst_ready     = rdy;
    #1;
    mem_drive(req_was, ack_was);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset          = 1'b0;
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    imem_ack       = tie_ack;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    mem_drive(1'b0, 1'b0);
  endtask

  task automatic gather(input int n, input bit rdy);
    for (int i = 0; i < 40 && acc.size() < n; i++) step(1'b0, 32'h0, rdy);
    chk("acc_len", acc.size(), n);
  endtask

  initial begin
    int acks;
    int n8;
    bit found;

    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    int n8;
    bit found;

    @(posedge clk);
    #1;
    cmp_en = 1'b1;

    // Streaming with ack tied high and decoder always ready.
    tie_ack = 1'b1;
    do_reset();
    chk1("s1_req_c1", imem_req, 1'b1);
    chk("s1_addr_c1", imem_addr, 32'h0);
    chk1("s1_valid_c1", inst_valid, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    chk("s1_addr_c2", imem_addr, 32'h4);
    chk("s1_pc_c2", inst_pc, 32'h0);
    step(1'b0, 32'h0, 1'b1);
    chk("s1_addr_c3", imem_addr, 32'h8);
    chk("s1_pc_c3", inst_pc, 32'h4);
    step(1'b0, 32'h0, 1'b1);
    chk("s1_pc_c4", inst_pc, 32'h8);
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (inst_valid && inst_pc == 32'h20) begin
        found = 1'b1;
        chk("s1_nop_word", inst_data, 32'h0000_0013);
      end
      step(1'b0, 32'h0, 1'b1);
    end
    chk1("s1_saw_0x20", found, 1'b1);

    // Back-pressure: FIFO fills after two acks, one pop reopens fetch.
    do_reset();
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      if (imem_req && imem_ack) acks++;
      step(1'b0, 32'h0, 1'b0);
    end
    chk("s2_acks", acks, 2);
    chk1("s2_req_full", imem_req, 1'b0);
    chk("s2_head", inst_pc, 32'h0);
    step(1'b0, 32'h0, 1'b1);
    chk1("s2_req_popcyc", imem_req, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    chk1("s2_req_after", imem_req, 1'b1);
    chk("s2_addr_after", imem_addr, 32'h8);
    chk("s2_head_after", inst_pc, 32'h4);

    // Redirect while the read to 0x8 is waiting on a slow memory.
    tie_ack   = 1'b0;
    ack_delay = 3;
    do_reset();
    acc.delete();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (imem_req && imem_addr == 32'h8) found = 1'b1;
      else step(1'b0, 32'h0, 1'b1);
    end
    chk1("s3_reach8", found, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h100, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    chk1("s3_drain_req", imem_req, 1'b1);
    chk("s3_drain_addr", imem_addr, 32'h8);
    gather(3, 1'b1);
    chk("s3_acc0", acc_at(0), 32'h0);
    chk("s3_acc1", acc_at(1), 32'h4);
    chk("s3_acc2", acc_at(2), 32'h100);
    n8 = 0;
    foreach (acc[i]) if (acc[i] == 32'h8) n8++;
    chk("s3_no8", n8, 0);

    // Second redirect lands while still draining.
    do_reset();
    acc.delete();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (imem_req && imem_addr == 32'h8) found = 1'b1;
      else step(1'b0, 32'h0, 1'b1);
    end
    chk1("s3b_reach8", found, 1'b1);
    step(1'b1, 32'h100, 1'b1);
    step(1'b1, 32'h300, 1'b1);
    gather(3, 1'b1);
    chk("s3b_acc2", acc_at(2), 32'h300);

    // Address wrap at the top of the space.
    tie_ack   = 1'b1;
    ack_delay = 0;
    do_reset();
    step(1'b1, 32'hFFFF_FFFC, 1'b1);
    acc.delete();
    gather(2, 1'b1);
    chk("s4_acc0", acc_at(0), 32'hFFFF_FFFC);
    chk("s4_acc1", acc_at(1), 32'h0);

    // Misaligned redirect.
    do_reset();
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h102, 1'b1);
`ifdef FETCH_MISALIGN_CHECK_EN
    step(1'b0, 32'h0, 1'b1);
    chk1("s5_fault", fetch_fault, 1'b1);
    chk1("s5_req0", imem_req, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    chk1("s5_fault_sticky", fetch_fault, 1'b1);
    step(1'b1, 32'h200, 1'b1);
    acc.delete();
    gather(1, 1'b1);
    chk("s5_resume", acc_at(0), 32'h200);
    chk1("s5_fault_clr", fetch_fault, 1'b0);
    // Misaligned redirect with a read in flight: drain, then halt.
    tie_ack   = 1'b0;
    ack_delay = 3;
    do_reset();
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h103, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    chk1("s5b_drain_req", imem_req, 1'b1);
    chk1("s5b_fault", fetch_fault, 1'b1);
    for (int i = 0; i < 10 && imem_req; i++) step(1'b0, 32'h0, 1'b1);
    chk1("s5b_halt_req", imem_req, 1'b0);
    chk1("s5b_fault_held", fetch_fault, 1'b1);
    tie_ack   = 1'b1;
    ack_delay = 0;
`else
    acc.delete();
    gather(1, 1'b1);
    chk("s5_aligned", acc_at(0), 32'h100);
    chk1("s5_nofault", fetch_fault, 1'b0);
`endif

    // Reset with a full FIFO.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0);
    chk1("s6_full_valid", inst_valid, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk1("s6_rst_valid", inst_valid, 1'b0);
    chk1("s6_rst_req", imem_req, 1'b0);
    chk("s6_rst_pc", inst_pc, 32'h0);
    chk("s6_rst_data", inst_data, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    mem_drive(1'b0, 1'b0);
    chk1("s6_restart_req", imem_req, 1'b1);
    chk("s6_restart_addr", imem_addr, 32'h0);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);

    @(posedge clk);
    #1;
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
